// File: rtl/float_normalize.sv
// Registered post-add normalizer: carry right-shift or leading-zero left-shift, packs an IEEE-754 single.
// Optional macro FLOAT_NORM_FAST_EN replaces the serial shifter with a one-cycle LZC + barrel shifter.
module float_normalize (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [24:0] in_mant,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_shift,
  output logic        out_zero,
  output logic        out_underflow,
  output logic        out_overflow
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // out_valid and its payload hold steady until out_ready is seen.
  state_t      state_q, state_d;
  logic        sign_q, sign_d;
  logic [7:0]  exp_q, exp_d;
  logic [23:0] mant_q, mant_d;
  logic        valid_d, zero_d, unf_d, ovf_d;
  logic [31:0] result_d;
  logic [4:0]  shift_d;

  assign in_ready = (state_q == IDLE) & ~rst;

`ifdef FLOAT_NORM_FAST_EN
  logic [4:0]  lz;
  logic [23:0] norm;

  // Highest set bit wins because the loop scans upward.
  function automatic logic [4:0] lzc24(input logic [23:0] v);
    lzc24 = 5'd24;
    for (int i = 0; i < 24; i++)
      if (v[i]) lzc24 = 5'(23 - i);
  endfunction

  assign lz   = lzc24(mant_q);
  assign norm = mant_q << lz;
`else
  logic [4:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    valid_d  = out_valid;
    result_d = out_result;
    shift_d  = out_shift;
    zero_d   = out_zero;
    unf_d    = out_underflow;
    ovf_d    = out_overflow;
`ifndef FLOAT_NORM_FAST_EN
    cnt_d    = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_sign;
          shift_d = 5'd0;
          zero_d  = 1'b0;
          unf_d   = 1'b0;
          ovf_d   = 1'b0;
`ifndef FLOAT_NORM_FAST_EN
          cnt_d   = 5'd0;
`endif
          if (in_exp == 8'hFF || (in_mant[24] && in_exp >= 8'hFE)) begin
            result_d = {in_sign, 8'hFF, 23'd0};
            ovf_d    = 1'b1;
            valid_d  = 1'b1;
            state_d  = DONE;
          end else if (in_mant == 25'd0) begin
            result_d = {in_sign, 31'd0};
            zero_d   = 1'b1;
            valid_d  = 1'b1;
            state_d  = DONE;
          end else if (in_exp == 8'd0) begin
            result_d = {in_sign, 31'd0};
            unf_d    = 1'b1;
            valid_d  = 1'b1;
            state_d  = DONE;
          end else if (in_mant[24]) begin
            // Carry: drop the LSB (truncation, no rounding).
            mant_d  = in_mant[24:1];
            exp_d   = in_exp + 8'd1;
            state_d = SHIFT;
          end else begin
            mant_d  = in_mant[23:0];
            exp_d   = in_exp;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
`ifdef FLOAT_NORM_FAST_EN
        valid_d = 1'b1;
        state_d = DONE;
        if ({3'd0, lz} >= exp_q) begin
          result_d = {sign_q, 31'd0};
          unf_d    = 1'b1;
          shift_d  = 5'(exp_q - 8'd1);
        end else begin
          result_d = {sign_q, exp_q - {3'd0, lz}, norm[22:0]};
          shift_d  = lz;
        end
`else
        if (mant_q[23]) begin
          result_d = {sign_q, exp_q, mant_q[22:0]};
          shift_d  = cnt_q;
          valid_d  = 1'b1;
          state_d  = DONE;
        end else if (exp_q == 8'd1) begin
          result_d = {sign_q, 31'd0};
          unf_d    = 1'b1;
          shift_d  = cnt_q;
          valid_d  = 1'b1;
          state_d  = DONE;
        end else begin
          mant_d = {mant_q[22:0], 1'b0};
          exp_d  = exp_q - 8'd1;
          cnt_d  = cnt_q + 5'd1;
        end
`endif
      end
      DONE: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      sign_q        <= 1'b0;
      exp_q         <= 8'd0;
      mant_q        <= 24'd0;
      out_valid     <= 1'b0;
      out_result    <= 32'd0;
      out_shift     <= 5'd0;
      out_zero      <= 1'b0;
      out_underflow <= 1'b0;
      out_overflow  <= 1'b0;
`ifndef FLOAT_NORM_FAST_EN
      cnt_q         <= 5'd0;
`endif
    end else begin
      state_q       <= state_d;
      sign_q        <= sign_d;
      exp_q         <= exp_d;
      mant_q        <= mant_d;
      out_valid     <= valid_d;
      out_result    <= result_d;
      out_shift     <= shift_d;
      out_zero      <= zero_d;
      out_underflow <= unf_d;
      out_overflow  <= ovf_d;
`ifndef FLOAT_NORM_FAST_EN
      cnt_q         <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_float_normalize.sv
// Self-checking bench for float_normalize: directed cases, backpressure, mid-operation reset, random vectors.
module tb_float_normalize;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = 8'd0;
  logic [24:0] in_mant = 25'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [4:0]  out_shift;
  logic        out_zero, out_underflow, out_overflow;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  float_normalize dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_shift(out_shift),
    .out_zero(out_zero), .out_underflow(out_underflow), .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference model: real-valued normalization with integer arithmetic.
  task automatic model(input logic s, input logic [7:0] e, input logic [24:0] m,
                       output logic [31:0] res, output logic [4:0] sh,
                       output logic z, output logic u, output logic o, output int lat);
    int ee, mm, k;
    z = 1'b0; u = 1'b0; o = 1'b0; sh = 5'd0; res = 32'd0; lat = 1;
    if (e == 8'hFF || (m[24] && e >= 8'hFE)) begin
      res = {s, 8'hFF, 23'd0}; o = 1'b1;
    end else if (m == 25'd0) begin
      res = {s, 31'd0}; z = 1'b1;
    end else if (e == 8'd0) begin
      res = {s, 31'd0}; u = 1'b1;
    end else begin
      ee = int'(e);
      mm = int'(m);
      if (mm >= (1 << 24)) begin mm = mm / 2; ee = ee + 1; end
      k = 0;
      while (mm < (1 << 23)) begin mm = mm * 2; k++; end
      if (k >= ee) begin
        res = {s, 31'd0}; u = 1'b1; sh = 5'(ee - 1); lat = ee + 1;
      end else begin
        res = {s, 8'(ee - k), 23'(mm - (1 << 23))}; sh = 5'(k); lat = 2 + k;
      end
`ifdef FLOAT_NORM_FAST_EN
      lat = 2;
`endif
    end
  endtask

  // Driver: entered and left at a negedge with the DUT idle.
  task automatic run_vec(input string tag, input logic s, input logic [7:0] e,
                         input logic [24:0] m, input int hold);
    logic [31:0] r; logic [4:0] sh; logic z, u, o; int lat, n;
    model(s, e, m, r, sh, z, u, o, lat);
    exp_q.push_back(r);
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m;
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (out_valid !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    check({tag, "_latency"}, 32'(n), 32'(lat));
    repeat (hold) @(negedge clk);
    check({tag, "_result"}, out_result, exp_q.pop_front());
    check({tag, "_shift"}, 32'(out_shift), 32'(sh));
    check({tag, "_flags"}, {29'd0, out_zero, out_underflow, out_overflow}, {29'd0, z, u, o});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_clr"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] held;
    logic [7:0]  re;
    logic [24:0] rm;
    int w, sel;

    // Reset state
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_shift_flags", {24'd0, out_shift, out_zero, out_underflow, out_overflow}, 32'd0);
    rst = 1'b0;
    #1 check("rst_release_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Directed cases
    run_vec("normalized", 1'b0, 8'h80, 25'h0800000, 0);
    run_vec("carry",      1'b0, 8'h7F, 25'h1800000, 0);
    run_vec("lead_zeros", 1'b0, 8'h85, 25'h0000100, 0);
    run_vec("zero",       1'b1, 8'h40, 25'h0000000, 0);
    run_vec("underflow",  1'b0, 8'h03, 25'h0000001, 0);
    run_vec("overflow",   1'b0, 8'hFE, 25'h1000000, 0);
    run_vec("exp_ff",     1'b1, 8'hFF, 25'h0123456, 0);
    run_vec("exp_zero",   1'b1, 8'h00, 25'h0800001, 0);
    run_vec("unf_edge",   1'b0, 8'h17, 25'h0000001, 0);
    run_vec("lz23_ok",    1'b1, 8'h18, 25'h0000001, 0);

    // Backpressure: result holds, second operand ignored while DONE
    exp_q.push_back(32'h40000000);
    in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'h80; in_mant = 25'h0800000;
    @(negedge clk);
    in_exp = 8'h10; in_mant = 25'h0000003;
    @(negedge clk);
    check("bp_valid", 32'(out_valid), 32'd1);
    held = out_result;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_stable", out_result, held);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    check("bp_result", out_result, exp_q.pop_front());
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    repeat (4) @(negedge clk);
    check("bp_no_second", 32'(out_valid), 32'd0);

    // Reset while in SHIFT
    in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'h85; in_mant = 25'h0000100;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1 check("rst_mid_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    #1 check("rst_mid_ready_back", 32'(in_ready), 32'd1);
    repeat (20) @(negedge clk);
    check("rst_mid_discard", 32'(out_valid), 32'd0);
    run_vec("post_rst", 1'b1, 8'h7F, 25'h0C00000, 0);

    // Randomized vectors
    for (int i = 0; i < 200; i++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0: re = 8'h00;
        1: re = 8'hFF;
        2: re = 8'($urandom_range(253, 254));
        3: re = 8'($urandom_range(1, 30));
        default: re = 8'($urandom_range(1, 254));
      endcase
      w = $urandom_range(0, 25);
      rm = 25'($urandom & ((32'd1 << w) - 32'd1));
      run_vec("rand", 1'($urandom_range(0, 1)), re, rm, $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/float_normalize.md
# float_normalize

Registered post-add normalizer for the single-precision float adder datapath. It accepts the adder's pre-normalization result: a sign, an 8-bit exponent and a 25-bit mantissa that carries the carry-out in bit 24 and the hidden bit in bit 23. It normalizes by a right shift on carry or iterative left shifts on leading zeros, and flags zero, underflow and overflow. It returns a packed IEEE-754 single over a valid/ready handshake.

## Interface
- No parameters.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  input operand valid.
- in_ready  out  1  block can accept; `(state==IDLE) & ~rst`.
- in_sign  in  1  result sign, passed through.
- in_exp  in  8  biased exponent of the unnormalized sum.
- in_mant  in  25  [24]=carry, [23]=hidden bit, [22:0]=fraction.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  downstream accepts the result.
- out_result  out  32  {sign, exp[7:0], frac[22:0]}.
- out_shift  out  5  number of left shifts applied (0 on the carry and zero paths).
- out_zero, out_underflow, out_overflow  out  1 each  status flags, valid with out_valid.

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- Reset values: out_valid, out_result, out_shift and all flags are 0. in_ready is 0 while rst is high.
- Capture occurs on `in_valid & in_ready`. Priority order at capture:
  - in_exp==255, or (in_mant[24] and in_exp>=254): result {sign,8'hFF,23'b0}, out_overflow=1, go to DONE.
  - in_mant==0: result {sign,31'b0}, out_zero=1, go to DONE.
  - in_exp==0: flush to {sign,31'b0}, out_underflow=1, go to DONE.
  - in_mant[24]: store mant>>1 and exp+1, go to SHIFT. The LSB is truncated; there is no rounding.
  - Otherwise: store the operands, go to SHIFT.
- SHIFT, evaluated once per cycle:
  - mant[23]==1: form the result from exp and mant[22:0], go to DONE.
  - Otherwise, if exp==1: flush to signed zero, out_underflow=1, go to DONE.
  - Otherwise: mant<<=1, exp-=1, shift count +1, stay in SHIFT.
- DONE: out_valid=1, with result and flags stable. On out_ready, go to IDLE and clear out_valid. There is no bypass, so a new capture is possible in the cycle after IDLE is re-entered.
- Asserting rst mid-operation aborts immediately to IDLE with all outputs at their reset values. The in-flight operand is discarded.

## Timing
- Latency counts edges from the capture edge to out_valid high:
  - Zero, overflow and underflow decided at capture: 1.
  - Normalized input or carry input: 2.
  - k leading zeros below bit 23: 2+k (maximum 25).
  - Underflow discovered in SHIFT: 2 + (in_exp-1).
- With out_ready held high, one result per (latency+1) cycles.
- Outputs are registered; in_ready is combinational from the state and rst only.

## Configuration
- FLOAT_NORM_FAST_EN defined:
  - SHIFT resolves in one cycle using a 24-bit leading-zero count and a barrel shifter.
  - If lzc >= exp, the result is an underflow flush.
  - Otherwise exp -= lzc, mant <<= lzc and out_shift = lzc.
  - All non-capture-decided latencies become 2.
- FLOAT_NORM_FAST_EN undefined: the serial one-bit-per-cycle shifter described above. Results and flags are bit-identical in both builds; only latency differs.

## Test plan
- **Normalized input:** sign=0, exp=8'h80, mant=25'h0800000 -> out_result=32'h40000000, out_shift=0, out_valid 2 edges after capture.
- **Carry input:** exp=8'h7F, mant=25'h1800000 -> out_result=32'h40400000, no flags, latency 2.
- **Leading zeros:** exp=8'h85, mant=25'h0000100 -> out_result=32'h3B000000, out_shift=15. Latency 17 serial, 2 with FLOAT_NORM_FAST_EN.
- **Zero input:** sign=1, mant=0 -> out_result=32'h80000000, out_zero=1, latency 1.
- **Underflow and overflow:**
  - exp=8'h03, mant=25'h0000001 -> out_result=32'h00000000, out_underflow=1.
  - exp=8'hFE, mant=25'h1000000 -> out_result=32'h7F800000, out_overflow=1.
- **Backpressure and reset:**
  - Hold out_ready=0 for 5 cycles in DONE: out_result stays stable, in_ready=0, and the second in_valid is not captured.
  - Assert rst during SHIFT: out_valid=0 and in_ready returns to 1 on the first cycle after rst deasserts.
